tl_d_beat_collector: RTL and testbench

- Passive consumer of the hart 0 data-port TileLink D channel, 32-bit beats.
- Watches D-channel handshakes, groups multi-beat data responses into one completed-response record, and buffers records in a small FIFO for the trace/Insight back end.
- Flags protocol violations seen on the channel.
- Never drives ready on the D channel; observation only.

---
 rtl/tl_d_beat_collector.sv | 210 +++++++++++++++++++++
 tb/tb_tl_d_beat_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tl_d_beat_collector.sv
// Passive TileLink D-channel monitor: groups multi-beat responses into
// one record, queues records for the trace back end, flags violations.
module tl_d_beat_collector #(
    parameter int DATA_W      = 32,
    parameter int MAX_LG_SIZE = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [1:0]        d_param,
    input  logic [3:0]        d_size,
    input  logic              d_source,
    input  logic              d_sink,
    input  logic              d_denied,
    input  logic              d_corrupt,
    input  logic [DATA_W-1:0] d_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_opcode,
    output logic [3:0]        rsp_size,
    output logic              rsp_source,
    output logic              rsp_sink,
    output logic              rsp_denied,
    output logic              rsp_corrupt,
    output logic [4:0]        rsp_beats,
    output logic [DATA_W-1:0] rsp_data0,
    output logic              err_protocol,
    output logic              err_overflow,
    input  logic              clear_err
);

    localparam int LgBpb = $clog2(DATA_W / 8);
    localparam int PtrW  = $clog2(FIFO_DEPTH);
    localparam int CntW  = PtrW + 1;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [3:0]        size;
        logic              source;
        logic              sink;
        logic              denied;
        logic              corrupt;
        logic [4:0]        beats;
        logic [DATA_W-1:0] data0;
    } rspRec_t;

    typedef enum logic {IDLE, BURST} state_t;

    state_t      state, stateNext;
    logic        fire;
    logic        isData;
    logic        sizeBad;
    logic [4:0]  expBeats;
    logic        protErr;
    logic        pushValid;
    rspRec_t     pushRec;

    logic [2:0]        curOpcode;
    logic [3:0]        curSize;
    logic              curSource;
    logic              curSink;
    logic              curDenied;
    logic              curCorrupt;
    logic [DATA_W-1:0] curData0;
    logic [4:0]        beatCnt;
    logic [4:0]        remaining;

    rspRec_t           mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wrPtr, rdPtr;
    logic [CntW-1:0]   count;
    logic              empty, full, pop, wrEn, drop;

    logic              unusedBits;

    assign unusedBits = ^{d_param, d_data};
    assign fire       = d_valid & d_ready;

    always_comb begin
        isData   = (d_opcode == 3'd1) || (d_opcode == 3'd5);
        sizeBad  = d_size > 4'(MAX_LG_SIZE);
        expBeats = 5'd1;
        if (isData && !sizeBad && d_size > 4'(LgBpb)) begin
            expBeats = 5'd1 << (d_size - 4'(LgBpb));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (fire && expBeats != 5'd1) stateNext = BURST;
            BURST: if (fire && remaining == 5'd1) stateNext = IDLE;
        endcase
    end

    always_comb begin
        protErr   = 1'b0;
        pushValid = 1'b0;
        pushRec   = '0;
        unique case (state)
            IDLE: begin
                if (fire) begin
                    protErr   = sizeBad;
                    pushValid = (expBeats == 5'd1);
                    pushRec   = '{d_opcode, d_size, d_source, d_sink,
                                  d_denied, d_corrupt, 5'd1, d_data};
                end
            end
            BURST: begin
                if (fire) begin
                    protErr   = (d_opcode != curOpcode) ||
                                (d_size != curSize) ||
                                (d_source != curSource) ||
                                (d_sink != curSink);
                    pushValid = (remaining == 5'd1);
                    pushRec   = '{curOpcode, curSize, curSource, curSink,
                                  curDenied | d_denied,
                                  curCorrupt | d_corrupt,
                                  beatCnt + 5'd1, curData0};
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            curOpcode  <= '0;
            curSize    <= '0;
            curSource  <= 1'b0;
            curSink    <= 1'b0;
            curDenied  <= 1'b0;
            curCorrupt <= 1'b0;
            curData0   <= '0;
            beatCnt    <= '0;
            remaining  <= '0;
        end else if (fire) begin
            if (state == IDLE) begin
                curOpcode  <= d_opcode;
                curSize    <= d_size;
                curSource  <= d_source;
                curSink    <= d_sink;
                curDenied  <= d_denied;
                curCorrupt <= d_corrupt;
                curData0   <= d_data;
                beatCnt    <= 5'd1;
                remaining  <= expBeats - 5'd1;
            end else begin
                curDenied  <= curDenied | d_denied;
                curCorrupt <= curCorrupt | d_corrupt;
                beatCnt    <= beatCnt + 5'd1;
                remaining  <= remaining - 5'd1;
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CntW'(FIFO_DEPTH));
    assign pop   = rsp_ready & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wrEn  = pushValid & (~full | pop);
    assign drop  = pushValid & full & ~pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wrEn) begin
                mem[wrPtr] <= pushRec;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            unique case (1'b1)
                wrEn & ~pop: count <= count + 1'b1;
                pop & ~wrEn: count <= count - 1'b1;
                default:     count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_protocol <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_protocol <= protErr | (err_protocol & ~clear_err);
            err_overflow <= drop | (err_overflow & ~clear_err);
        end
    end

    assign rsp_valid   = ~empty;
    assign rsp_opcode  = mem[rdPtr].opcode;
    assign rsp_size    = mem[rdPtr].size;
    assign rsp_source  = mem[rdPtr].source;
    assign rsp_sink    = mem[rdPtr].sink;
    assign rsp_denied  = mem[rdPtr].denied;
    assign rsp_corrupt = mem[rdPtr].corrupt;
    assign rsp_beats   = mem[rdPtr].beats;
    assign rsp_data0   = mem[rdPtr].data0;

endmodule

// File: tb/tb_tl_d_beat_collector.sv
// Directed bench for tl_d_beat_collector: bursts, gaps, overflow,
// protocol errors and mid-burst reset.
module tb_tl_d_beat_collector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        d_valid = 1'b0;
    logic        d_ready = 1'b0;
    logic [2:0]  d_opcode = '0;
    logic [1:0]  d_param = '0;
    logic [3:0]  d_size = '0;
    logic        d_source = 1'b0;
    logic        d_sink = 1'b0;
    logic        d_denied = 1'b0;
    logic        d_corrupt = 1'b0;
    logic [31:0] d_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_opcode;
    logic [3:0]  rsp_size;
    logic        rsp_source;
    logic        rsp_sink;
    logic        rsp_denied;
    logic        rsp_corrupt;
    logic [4:0]  rsp_beats;
    logic [31:0] rsp_data0;
    logic        err_protocol;
    logic        err_overflow;
    logic        clear_err = 1'b0;

    int checks = 0;
    int failures = 0;

    tl_d_beat_collector dut (
        .clock(clock), .reset(reset),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied),
        .d_corrupt(d_corrupt), .d_data(d_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_opcode(rsp_opcode), .rsp_size(rsp_size),
        .rsp_source(rsp_source), .rsp_sink(rsp_sink),
        .rsp_denied(rsp_denied), .rsp_corrupt(rsp_corrupt),
        .rsp_beats(rsp_beats), .rsp_data0(rsp_data0),
        .err_protocol(err_protocol), .err_overflow(err_overflow),
        .clear_err(clear_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [2:0] op, input logic [3:0] sz,
                        input logic src, input logic cor,
                        input logic [31:0] dat);
        d_valid   = 1'b1;
        d_ready   = 1'b1;
        d_opcode  = op;
        d_size    = sz;
        d_source  = src;
        d_sink    = 1'b0;
        d_denied  = 1'b0;
        d_corrupt = cor;
        d_data    = dat;
        step();
        d_valid   = 1'b0;
        d_ready   = 1'b0;
        d_corrupt = 1'b0;
    endtask

    task automatic popOne();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic clearErr();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        reset = 1'b0;
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_opcode", rsp_opcode, 3'd0);
        chk("rst_beats", rsp_beats, 5'd0);
        chk("rst_data0", rsp_data0, 32'd0);
        chk("rst_errp", err_protocol, 1'b0);
        chk("rst_erro", err_overflow, 1'b0);

        // single-beat AccessAck
        beat(3'd0, 4'd2, 1'b1, 1'b0, 32'h11);
        chk("single_valid", rsp_valid, 1'b1);
        chk("single_opcode", rsp_opcode, 3'd0);
        chk("single_beats", rsp_beats, 5'd1);
        chk("single_source", rsp_source, 1'b1);
        popOne();
        chk("single_popped", rsp_valid, 1'b0);

        // AccessAckData size 0 still one beat
        beat(3'd1, 4'd0, 1'b0, 1'b0, 32'h55);
        chk("small_beats", rsp_beats, 5'd1);
        chk("small_data0", rsp_data0, 32'h55);
        popOne();

        // 4-beat burst, corrupt on third beat
        beat(3'd1, 4'd4, 1'b0, 1'b0, 32'hA0);
        beat(3'd1, 4'd4, 1'b0, 1'b0, 32'hA1);
        beat(3'd1, 4'd4, 1'b0, 1'b1, 32'hA2);
        chk("burst_early", rsp_valid, 1'b0);
        beat(3'd1, 4'd4, 1'b0, 1'b0, 32'hA3);
        chk("burst_valid", rsp_valid, 1'b1);
        chk("burst_beats", rsp_beats, 5'd4);
        chk("burst_data0", rsp_data0, 32'hA0);
        chk("burst_corrupt", rsp_corrupt, 1'b1);
        chk("burst_opcode", rsp_opcode, 3'd1);
        chk("burst_size", rsp_size, 4'd4);
        popOne();
        chk("burst_one_rec", rsp_valid, 1'b0);

        // same burst with ready gaps
        for (int b = 0; b < 4; b++) begin
            beat(3'd1, 4'd4, 1'b0, b == 2, 32'hA0 + 32'(b));
            if (b < 3) begin
                d_valid = 1'b1;
                d_ready = 1'b0;
                repeat (3) step();
                d_valid = 1'b0;
                chk("gap_early", rsp_valid, 1'b0);
            end
        end
        chk("gap_valid", rsp_valid, 1'b1);
        chk("gap_beats", rsp_beats, 5'd4);
        chk("gap_data0", rsp_data0, 32'hA0);
        chk("gap_corrupt", rsp_corrupt, 1'b1);
        popOne();
        chk("gap_one_rec", rsp_valid, 1'b0);

        // overflow: sizes 0..3 kept, size 5 dropped
        for (int i = 0; i < 4; i++) beat(3'd0, 4'(i), 1'b0, 1'b0, 32'(i));
        chk("ovf_none", err_overflow, 1'b0);
        beat(3'd0, 4'd5, 1'b0, 1'b0, 32'h5);
        chk("ovf_set", err_overflow, 1'b1);
        chk("ovf_head", rsp_size, 4'd0);
        rsp_ready = 1'b1;
        beat(3'd0, 4'd6, 1'b0, 1'b0, 32'h6);
        rsp_ready = 1'b0;
        chk("pp_head", rsp_size, 4'd1);
        chk("pp_errkeep", err_overflow, 1'b1);
        chk("ord0", rsp_size, 4'd1);
        popOne();
        chk("ord1", rsp_size, 4'd2);
        popOne();
        chk("ord2", rsp_size, 4'd3);
        popOne();
        chk("ord3", rsp_size, 4'd6);
        chk("ord3_valid", rsp_valid, 1'b1);
        popOne();
        chk("ovf_drained", rsp_valid, 1'b0);
        clearErr();
        chk("ovf_cleared", err_overflow, 1'b0);

        // source flips on second beat
        beat(3'd1, 4'd4, 1'b0, 1'b0, 32'hB0);
        chk("perr_clean", err_protocol, 1'b0);
        beat(3'd1, 4'd4, 1'b1, 1'b0, 32'hB1);
        chk("perr_set", err_protocol, 1'b1);
        beat(3'd1, 4'd4, 1'b0, 1'b0, 32'hB2);
        beat(3'd1, 4'd4, 1'b0, 1'b0, 32'hB3);
        chk("perr_valid", rsp_valid, 1'b1);
        chk("perr_beats", rsp_beats, 5'd4);
        popOne();
        clearErr();
        chk("perr_cleared", err_protocol, 1'b0);

        // oversize response
        beat(3'd1, 4'd7, 1'b0, 1'b0, 32'hC0);
        chk("big_err", err_protocol, 1'b1);
        chk("big_beats", rsp_beats, 5'd1);
        chk("big_size", rsp_size, 4'd7);
        popOne();

        // clear and new error together keeps the flag
        clear_err = 1'b1;
        beat(3'd1, 4'd8, 1'b0, 1'b0, 32'hC1);
        clear_err = 1'b0;
        chk("clr_race", err_protocol, 1'b1);
        popOne();
        clearErr();
        chk("clr_p", err_protocol, 1'b0);
        chk("clr_o", err_overflow, 1'b0);

        // largest legal burst: 64 bytes = 16 beats
        for (int b = 0; b < 16; b++) beat(3'd5, 4'd6, 1'b1, 1'b0, 32'(b));
        chk("max_beats", rsp_beats, 5'd16);
        chk("max_opcode", rsp_opcode, 3'd5);
        chk("max_errp", err_protocol, 1'b0);
        popOne();

        // reset after beat 2 of 4
        beat(3'd5, 4'd4, 1'b0, 1'b0, 32'hD0);
        beat(3'd5, 4'd4, 1'b0, 1'b0, 32'hD1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", rsp_valid, 1'b0);
        beat(3'd0, 4'd2, 1'b0, 1'b0, 32'hE0);
        chk("post_rst_valid", rsp_valid, 1'b1);
        chk("post_rst_beats", rsp_beats, 5'd1);
        chk("post_rst_errp", err_protocol, 1'b0);
        popOne();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
